// File: rtl/apb_pkg.sv
// Shared APB definitions: slave state encodings, bus width and address checking.
package apb_pkg;

  localparam int APB_DW = 32;

  // Slave state encodings; the master uses the same values for its states.
  localparam logic S_IDLE   = 1'b0;
  localparam logic S_ACCESS = 1'b1;

  typedef enum logic {
    ST_IDLE   = S_IDLE,
    ST_ACCESS = S_ACCESS
  } slv_state_e;

  // Flags a byte address that is misaligned or beyond the word window.
  // Bit 31 is left to the master's decode and never flags an error.
  function automatic logic addr_err(input logic [31:0] paddr, input int addr_w);
    logic err;
    err = 1'b0;
    for (int i = 0; i < 31; i++) begin
      if ((i < 2) || (i >= addr_w + 2)) begin
        err = err | paddr[i];
      end
    end
    return err;
  endfunction

endpackage

// File: rtl/apb_slave_mem_array.sv
// Word storage for the APB slave: async clear, synchronous write and a
// registered read port loaded on demand.
module apb_slave_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic              re,
  input  logic              rzero,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  // Next memory image and read register; rzero forces a zero load for
  // error transfers so stale data never reaches the bus.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = rzero ? '0 : mem_q[raddr];
    end
  end

  // Storage and read register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with word memory, programmable wait states and PSLVERR.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for a setup phase; latches address/control on it
// ST_ACCESS | wait-state countdown, then PREADY until PENABLE completes
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic              PREADY,
  output logic [APB_DW-1:0] PRDATA,
  output logic              PSLVERR
);

  slv_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              wr_q, wr_d;
  logic [APB_DW-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              setup;
  logic              mem_we;
  logic              ready;
  logic              setup_err;
  logic [APB_DW-1:0] rd_data;

  assign setup_err = addr_err(PADDR, ADDR_W);

  // Next-state logic: latch on setup, count waits, complete or abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    setup   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          setup   = 1'b1;
          idx_d   = PADDR[ADDR_W+1:2];
          wr_d    = PWRITE;
          wdata_d = PWDATA;
          err_d   = setup_err;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!PSEL) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (PENABLE) begin
          mem_we  = wr_q && !err_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and latched transfer registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  apb_slave_mem_array #(
    .ADDR_W (ADDR_W),
    .DW     (APB_DW)
  ) u_array (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (wdata_q),
    .re    (setup),
    .rzero (setup_err),
    .raddr (PADDR[ADDR_W+1:2]),
    .rdata (rd_data)
  );

  // Bus outputs come from registers only and are zero unless PREADY is high.
  always_comb begin
    ready   = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
    PREADY  = ready;
    PSLVERR = ready && err_q;
    PRDATA  = (ready && !wr_q && !err_q) ? rd_data : '0;
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
module tb_apb_slave_mem;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        sel0 = 1'b0, sel3 = 1'b0;
  logic        PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic        rdy0, rdy3, err0, err3;
  logic [31:0] rd0, rd3;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_slave_mem #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(sel0), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(rdy0), .PRDATA(rd0), .PSLVERR(err0));

  apb_slave_mem #(.ADDR_W(8), .WAIT_CYCLES(3)) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(sel3), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(rdy3), .PRDATA(rd3), .PSLVERR(err3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full transfer starting just after a rising edge; returns data, error
  // flag and number of PREADY-low access cycles. Leaves the bus idle, so
  // consecutive calls are back-to-back.
  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int nwait);
    logic done;
    logic rdy, e;
    logic [31:0] dat;
    done = 1'b0;
    nwait = 0;
    rd = '0;
    er = 1'b0;
    if (d == 0) sel0 = 1'b1; else sel3 = 1'b1;
    PENABLE = 1'b0;
    PWRITE = w;
    PADDR = a;
    PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge PCLK);
      rdy = (d == 0) ? rdy0 : rdy3;
      dat = (d == 0) ? rd0 : rd3;
      e   = (d == 0) ? err0 : err3;
      if (rdy) begin
        done = 1'b1;
        rd = dat;
        er = e;
      end else begin
        nwait++;
        chk("zero_while_wait", {dat[31:1], dat[0] | e}, 32'h0);
      end
    end
    if (!done) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge PCLK); #1;
    sel0 = 1'b0;
    sel3 = 1'b0;
    PENABLE = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          nw;

  initial begin
    #1;
    chk("rst_ready0", {31'd0, rdy0}, 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_err3", {31'd0, err3}, 32'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Wait-state read after reset
    xfer(3, 1'b0, 32'h0, 32'h0, rd, er, nw);
    chk("w3_read_waits", nw, 32'd3);
    chk("w3_read_data", rd, 32'h0);
    chk("w3_read_err", {31'd0, er}, 32'd0);

    // Zero-wait write then read
    xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, rd, er, nw);
    chk("w0_write_waits", nw, 32'd0);
    chk("w0_write_err", {31'd0, er}, 32'd0);
    xfer(0, 1'b0, 32'h04, 32'h0, rd, er, nw);
    chk("w0_read_waits", nw, 32'd0);
    chk("w0_read_data", rd, 32'hDEADBEEF);
    chk("w0_read_err", {31'd0, er}, 32'd0);

    // Misaligned write is rejected and leaves memory alone
    xfer(0, 1'b1, 32'h06, 32'h1234, rd, er, nw);
    chk("misalign_err", {31'd0, er}, 32'd1);
    xfer(0, 1'b0, 32'h04, 32'h0, rd, er, nw);
    chk("misalign_keep", rd, 32'hDEADBEEF);

    // Address boundaries
    xfer(0, 1'b0, 32'h3FC, 32'h0, rd, er, nw);
    chk("top_read_err", {31'd0, er}, 32'd0);
    chk("top_read_data", rd, 32'h0);
    xfer(0, 1'b1, 32'h3FC, 32'hCAFEF00D, rd, er, nw);
    xfer(0, 1'b0, 32'h3FC, 32'h0, rd, er, nw);
    chk("top_rw_data", rd, 32'hCAFEF00D);
    xfer(0, 1'b1, 32'h400, 32'h11111111, rd, er, nw);
    chk("oor_write_err", {31'd0, er}, 32'd1);
    xfer(0, 1'b0, 32'h000, 32'h0, rd, er, nw);
    chk("oor_no_alias", rd, 32'h0);
    xfer(0, 1'b0, 32'h400, 32'h0, rd, er, nw);
    chk("oor_read_err", {31'd0, er}, 32'd1);
    chk("oor_read_zero", rd, 32'h0);
    xfer(0, 1'b1, 32'h8000_0010, 32'h00000055, rd, er, nw);
    chk("bit31_err", {31'd0, er}, 32'd0);
    xfer(0, 1'b0, 32'h10, 32'h0, rd, er, nw);
    chk("bit31_map", rd, 32'h00000055);

    // Back-to-back transfers, no idle gap
    xfer(3, 1'b1, 32'h08, 32'hA5A5A5A5, rd, er, nw);
    xfer(3, 1'b1, 32'h0C, 32'h5A5A5A5A, rd, er, nw);
    chk("b2b_wr_waits", nw, 32'd3);
    xfer(3, 1'b0, 32'h08, 32'h0, rd, er, nw);
    chk("b2b_rd08", rd, 32'hA5A5A5A5);
    xfer(3, 1'b0, 32'h0C, 32'h0, rd, er, nw);
    chk("b2b_rd0c", rd, 32'h5A5A5A5A);
    chk("b2b_rd_waits", nw, 32'd3);

    // Reset during wait states of a write
    sel3 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h99999999;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    #1;
    chk("rst_mid_ready", {31'd0, rdy3}, 32'd0);
    chk("rst_mid_out", {rd3[31:1], rd3[0] | err3}, 32'd0);
    sel3 = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(3, 1'b0, 32'h10, 32'h0, rd, er, nw);
    chk("rst_no_write", rd, 32'h0);
    xfer(3, 1'b0, 32'h08, 32'h0, rd, er, nw);
    chk("rst_cleared", rd, 32'h0);
    xfer(0, 1'b0, 32'h04, 32'h0, rd, er, nw);
    chk("rst_cleared0", rd, 32'h0);

    // Select dropped mid-access aborts without writing
    sel3 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h14; PWDATA = 32'h00000077;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    sel3 = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("abort_ready", {31'd0, rdy3}, 32'd0);
    @(posedge PCLK); #1;
    xfer(3, 1'b0, 32'h14, 32'h0, rd, er, nw);
    chk("abort_no_write", rd, 32'h0);
    chk("abort_idle_waits", nw, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
